stall_flush_ctrl: RTL and testbench

STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

---
 rtl/stall_flush_ctrl_pkg.sv | 22 ++
 rtl/stall_flush_ctrl_credit_counter.sv | 44 ++++
 rtl/stall_flush_ctrl.sv | 157 +++++++++++++++
 tb/tb_stall_flush_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stall_flush_ctrl_pkg.sv
// Shared types and defaults for the stall/flush controller.
// State enum for the flush FSM plus the default parameter values.
// The counter-width helper keeps every counter at least one bit wide.
package stall_flush_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int DEF_NUM_RS       = 2;
  localparam int DEF_RS_DEPTH     = 8;
  localparam int DEF_ROB_DEPTH    = 16;
  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int DEF_STARVE_LIMIT = 4;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stall_flush_ctrl_credit_counter.sv
// Free-entry credit counter, 0..DEPTH, resets and loads to DEPTH.
// Latency: count updates on the clock edge after inc/dec/load.
// Over/underflow saturates and pulses err for the cycle it happens.
module credit_counter
  import stall_flush_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  input  logic          load,
  output logic [CW-1:0] count,
  output logic          err
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic overflow;
  logic underflow;

  // Detect an illegal step; a load wins and hides any same-cycle step.
  always_comb begin
    overflow  = inc & ~dec & (count == FULL);
    underflow = dec & ~inc & (count == '0);
    err       = ~load & (overflow | underflow);
  end

  // Counter register: inc and dec together cancel, illegal steps hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= FULL;
    end else if (load) begin
      count <= FULL;
    end else if (inc & ~dec & ~overflow) begin
      count <= count + 1'b1;
    end else if (dec & ~inc & ~underflow) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/stall_flush_ctrl.sv
// Dispatch stall, mispredict flush and memory-port arbitration control.
// Latency: ready/enables/grants are combinational; credits update next edge.
// Dispatch stalls when the target RS or the ROB has no free entry or in flush.
module stall_flush_ctrl
  import stall_flush_ctrl_pkg::*;
#(
  parameter  int NUM_RS       = DEF_NUM_RS,
  parameter  int RS_DEPTH     = DEF_RS_DEPTH,
  parameter  int ROB_DEPTH    = DEF_ROB_DEPTH,
  parameter  int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter  int STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int CLS_W        = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dispatch_valid,
  input  logic [CLS_W-1:0]  dispatch_class,
  input  logic [NUM_RS-1:0] rs_release,
  input  logic              rob_retire,
  input  logic              branch_mispredict,
  input  logic              commit_wr_mem,
  input  logic              ex_rd_mem,
  input  logic              if_rd_mem,
  output logic              dispatch_ready,
  output logic [NUM_RS-1:0] rs_enable,
  output logic              rob_enable,
  output logic              grant_commit,
  output logic              grant_ex,
  output logic              grant_if,
  output logic              if_enable,
  output logic              flush,
  output logic              credit_err
);

  localparam int RS_CW  = cnt_w(RS_DEPTH);
  localparam int ROB_CW = cnt_w(ROB_DEPTH);
  localparam int ST_CW  = cnt_w(STARVE_LIMIT);
  localparam int FL_CW  = cnt_w(FLUSH_CYCLES);
  localparam logic [ST_CW-1:0] STARVE_MAX = ST_CW'(STARVE_LIMIT);
  localparam logic [FL_CW-1:0] FLUSH_LAST = FL_CW'(FLUSH_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [FL_CW-1:0]   flush_cnt;
  logic [FL_CW-1:0]   flush_cnt_nxt;
  logic [ST_CW-1:0]   starve_cnt;
  logic [RS_CW-1:0]   rs_free [NUM_RS];
  logic [ROB_CW-1:0]  rob_free;
  logic [NUM_RS-1:0]  rs_err;
  logic               rob_err;
  logic               run;
  logic               class_free;
  logic               fire;
  logic               starved;

  assign run   = (state == RUN);
  assign flush = (state == FLUSH);

  // Flush FSM state register; reset aborts a flush without a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Flush FSM next state: a mispredict (re)starts the window, else count down.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (branch_mispredict) begin
      state_nxt     = FLUSH;
      flush_cnt_nxt = FLUSH_LAST;
    end else if (state == FLUSH) begin
      if (flush_cnt == '0) begin
        state_nxt = RUN;
      end else begin
        flush_cnt_nxt = flush_cnt - 1'b1;
      end
    end
  end

  // Dispatch gating: needs RUN, a ROB credit and a credit in the target class.
  always_comb begin
    class_free = 1'b0;
    rs_enable  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (int'(dispatch_class) == i && rs_free[i] != '0) class_free = 1'b1;
    end
    dispatch_ready = run & (rob_free != '0) & class_free;
    fire           = dispatch_valid & dispatch_ready;
    for (int i = 0; i < NUM_RS; i++) begin
      rs_enable[i] = fire & (int'(dispatch_class) == i);
    end
    rob_enable = fire;
  end

  // Memory-port arbitration; a starved fetch jumps ahead of load execute.
  always_comb begin
    starved      = (starve_cnt == STARVE_MAX);
    grant_commit = commit_wr_mem;
    grant_ex     = 1'b0;
    grant_if     = 1'b0;
    if (run && !commit_wr_mem) begin
      if (if_rd_mem && starved)  grant_if = 1'b1;
      else if (ex_rd_mem)        grant_ex = 1'b1;
      else if (if_rd_mem)        grant_if = 1'b1;
    end
    if_enable = run & ~(dispatch_valid & ~dispatch_ready) & (grant_if | ~if_rd_mem);
  end

  // Count consecutive denied fetch requests, saturating at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (run && if_rd_mem && !grant_if) begin
      if (!starved) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Sticky credit error: any counter over/underflow latches until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      credit_err <= 1'b0;
    end else if ((|rs_err) | rob_err) begin
      credit_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_RS; g++) begin : g_rs
    credit_counter #(.DEPTH(RS_DEPTH), .CW(RS_CW)) u_rs_credit (
      .clock (clock),
      .reset (reset),
      .inc   (rs_release[g]),
      .dec   (rs_enable[g]),
      .load  (branch_mispredict),
      .count (rs_free[g]),
      .err   (rs_err[g])
    );
  end

  credit_counter #(.DEPTH(ROB_DEPTH), .CW(ROB_CW)) u_rob_credit (
    .clock (clock),
    .reset (reset),
    .inc   (rob_retire),
    .dec   (fire),
    .load  (branch_mispredict),
    .count (rob_free),
    .err   (rob_err)
  );

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Self-checking bench for stall_flush_ctrl: directed table, corner sequences,
// and randomized traffic against a free-count / remaining-flush model.
module tb_stall_flush_ctrl;
  import stall_flush_ctrl_pkg::*;

  localparam int NRS = 2, RSD = 8, ROBD = 16, FLC = 2, STL = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       dispatch_valid;
  logic [0:0] dispatch_class;
  logic [1:0] rs_release;
  logic       rob_retire, branch_mispredict, commit_wr_mem, ex_rd_mem, if_rd_mem;
  logic       dispatch_ready;
  logic [1:0] rs_enable;
  logic       rob_enable, grant_commit, grant_ex, grant_if, if_enable, flush, credit_err;

  stall_flush_ctrl #(
    .NUM_RS(NRS), .RS_DEPTH(RSD), .ROB_DEPTH(ROBD),
    .FLUSH_CYCLES(FLC), .STARVE_LIMIT(STL)
  ) dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_class(dispatch_class),
    .rs_release(rs_release), .rob_retire(rob_retire),
    .branch_mispredict(branch_mispredict),
    .commit_wr_mem(commit_wr_mem), .ex_rd_mem(ex_rd_mem), .if_rd_mem(if_rd_mem),
    .dispatch_ready(dispatch_ready), .rs_enable(rs_enable), .rob_enable(rob_enable),
    .grant_commit(grant_commit), .grant_ex(grant_ex), .grant_if(grant_if),
    .if_enable(if_enable), .flush(flush), .credit_err(credit_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_rs[NRS];
  int m_rob;
  int m_flush_left;
  int m_starve;
  bit m_err;
  bit e_ready, e_roben, e_gc, e_ge, e_gi, e_ifen, e_flush;
  int e_rsen;

  task automatic model_reset();
    for (int i = 0; i < NRS; i++) m_rs[i] = RSD;
    m_rob = ROBD; m_flush_left = 0; m_starve = 0; m_err = 0;
  endtask

  task automatic model_eval();
    bit run; bit fire; int cls;
    run  = (m_flush_left == 0);
    cls  = int'(dispatch_class);
    e_ready = run && m_rob > 0 && m_rs[cls] > 0;
    fire    = dispatch_valid && e_ready;
    e_rsen  = fire ? (1 << cls) : 0;
    e_roben = fire;
    e_gc = commit_wr_mem; e_ge = 0; e_gi = 0;
    if (run && !commit_wr_mem) begin
      if (if_rd_mem && m_starve == STL) e_gi = 1;
      else if (ex_rd_mem)               e_ge = 1;
      else if (if_rd_mem)               e_gi = 1;
    end
    e_ifen  = run && !(dispatch_valid && !e_ready) && (e_gi || !if_rd_mem);
    e_flush = !run;
  endtask

  // New free count after one cycle of +inc / -dec; illegal steps hold.
  function automatic int cnt_next(input int c, input int d, input bit inc, input bit dec);
    int n;
    n = c + int'(inc) - int'(dec);
    return (n < 0 || n > d) ? c : n;
  endfunction

  function automatic bit cnt_bad(input int c, input int d, input bit inc, input bit dec);
    int n;
    n = c + int'(inc) - int'(dec);
    return (n < 0 || n > d);
  endfunction

  // Advance the model one clock; call after model_eval with inputs stable.
  task automatic model_update();
    bit run; bit fire; int cls;
    run  = (m_flush_left == 0);
    cls  = int'(dispatch_class);
    fire = dispatch_valid && e_ready;
    if (run && if_rd_mem && !e_gi) m_starve = (m_starve < STL) ? m_starve + 1 : STL;
    else                           m_starve = 0;
    if (branch_mispredict) begin
      for (int i = 0; i < NRS; i++) m_rs[i] = RSD;
      m_rob = ROBD;
      m_flush_left = FLC;
    end else begin
      for (int i = 0; i < NRS; i++) begin
        if (cnt_bad(m_rs[i], RSD, rs_release[i], fire && cls == i)) m_err = 1;
        m_rs[i] = cnt_next(m_rs[i], RSD, rs_release[i], fire && cls == i);
      end
      if (cnt_bad(m_rob, ROBD, rob_retire, fire)) m_err = 1;
      m_rob = cnt_next(m_rob, ROBD, rob_retire, fire);
      if (m_flush_left > 0) m_flush_left--;
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, " ready"},     dispatch_ready, e_ready);
    chk({tag, " rs_enable"}, rs_enable, e_rsen);
    chk({tag, " rob_enable"}, rob_enable, e_roben);
    chk({tag, " grant_commit"}, grant_commit, e_gc);
    chk({tag, " grant_ex"},  grant_ex, e_ge);
    chk({tag, " grant_if"},  grant_if, e_gi);
    chk({tag, " if_enable"}, if_enable, e_ifen);
    chk({tag, " flush"},     flush, e_flush);
    chk({tag, " credit_err"}, credit_err, m_err);
  endtask

  task automatic set_in(input bit v, input int c, input int rel, input bit ret,
                        input bit mis, input bit cm, input bit ex, input bit ifr);
    dispatch_valid = v; dispatch_class = 1'(c); rs_release = 2'(rel);
    rob_retire = ret; branch_mispredict = mis;
    commit_wr_mem = cm; ex_rd_mem = ex; if_rd_mem = ifr;
  endtask

  // One clock: settle, compare against the model, then step DUT and model.
  task automatic cycle(input string tag);
    #1;
    model_eval();
    model_check(tag);
    model_update();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit v; int c; int rel; bit ret, mis, cm, ex, ifr;
    bit rdy; int rsen; bit roben, gc, ge, gi, ifen, fl;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit v, int c, int rel, bit ret, bit mis, bit cm, bit ex, bit ifr,
                              bit rdy, int rsen, bit roben, bit gc, bit ge, bit gi, bit ifen, bit fl);
    vec_t t;
    t.v = v; t.c = c; t.rel = rel; t.ret = ret; t.mis = mis; t.cm = cm; t.ex = ex; t.ifr = ifr;
    t.rdy = rdy; t.rsen = rsen; t.roben = roben; t.gc = gc; t.ge = ge; t.gi = gi;
    t.ifen = ifen; t.fl = fl;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //                v c rel rt ms cm ex if   rdy rsen ren gc ge gi ifen fl
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,2,1,0,0,0,1,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));   // class 1 exhausted
    tbl.push_back(mk(0,1,2,0,0,0,0,0, 0,0,0,0,0,0,1,0));   // release one class-1 entry
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,2,1,0,0,0,1,0));   // ready again
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,0,0,0,1,1, 1,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,1, 1,0,0,0,0,1,1,0));   // starved fetch wins
    tbl.push_back(mk(0,0,0,0,0,1,1,1, 1,0,0,1,0,0,0,0));   // commit beats all
    tbl.push_back(mk(1,0,0,0,0,1,0,1, 1,1,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0,0, 1,0,0,0,0,0,1,0));   // mispredict
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,1,1,0, 0,0,0,1,0,0,0,1));   // only commit in flush
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 1,2,1,0,0,0,1,0));   // back to RUN, full

    do_reset();
    #1;
    chk("reset flush", flush, 0);
    chk("reset credit_err", credit_err, 0);
    chk("reset rob_free", dut.rob_free, ROBD);
    chk("reset rs_free1", dut.rs_free[1], RSD);

    foreach (tbl[k]) begin
      set_in(tbl[k].v, tbl[k].c, tbl[k].rel, tbl[k].ret, tbl[k].mis, tbl[k].cm, tbl[k].ex, tbl[k].ifr);
      #1;
      chk($sformatf("tbl%0d ready", k), dispatch_ready, tbl[k].rdy);
      chk($sformatf("tbl%0d rs_enable", k), rs_enable, tbl[k].rsen);
      chk($sformatf("tbl%0d rob_enable", k), rob_enable, tbl[k].roben);
      chk($sformatf("tbl%0d grant_commit", k), grant_commit, tbl[k].gc);
      chk($sformatf("tbl%0d grant_ex", k), grant_ex, tbl[k].ge);
      chk($sformatf("tbl%0d grant_if", k), grant_if, tbl[k].gi);
      chk($sformatf("tbl%0d if_enable", k), if_enable, tbl[k].ifen);
      chk($sformatf("tbl%0d flush", k), flush, tbl[k].fl);
      chk($sformatf("tbl%0d credit_err", k), credit_err, 0);
      @(posedge clock);
      @(negedge clock);
    end

    // Fire and release on the same counter cancel; release from empty works.
    do_reset();
    for (int i = 0; i < 5; i++) begin set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle("cls0 fill"); end
    set_in(1, 0, 1, 0, 0, 0, 0, 0); cycle("fire+rel");
    chk("fire+rel rs_free0", dut.rs_free[0], 3);
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      #1; chk($sformatf("drain%0d ready", i), dispatch_ready, (i < 3) ? 1 : 0);
      cycle("drain");
    end
    set_in(0, 0, 1, 0, 0, 0, 0, 0); cycle("rel from 0");
    set_in(1, 0, 0, 0, 0, 0, 0, 0); #1; chk("after rel ready", dispatch_ready, 1); cycle("redisp");
    set_in(1, 0, 0, 0, 0, 0, 0, 0); #1; chk("empty again ready", dispatch_ready, 0); cycle("empty");

    // Flush window timing and restart.
    do_reset();
    for (int i = 0; i < 3; i++) begin set_in(1, 1, 0, 0, 0, 0, 0, 0); cycle("pre flush"); end
    set_in(0, 0, 0, 0, 1, 0, 0, 0); cycle("mis t");
    set_in(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("t+1 flush", flush, 1);
    chk("t+1 rob_free", dut.rob_free, ROBD);
    chk("t+1 rs_free1", dut.rs_free[1], RSD);
    cycle("t+1");
    #1; chk("t+2 flush", flush, 1); cycle("t+2");
    #1; chk("t+3 flush", flush, 0); cycle("t+3");
    set_in(0, 0, 0, 0, 1, 0, 0, 0); cycle("mis2 t");
    #1; chk("re t+1 flush", flush, 1); cycle("re t+1");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk("re t+2 flush", flush, 1); cycle("re t+2");
    #1; chk("re t+3 flush", flush, 1); cycle("re t+3");
    #1; chk("re t+4 flush", flush, 0); cycle("re t+4");

    // Retire into a full ROB: saturate and latch the error until reset.
    do_reset();
    set_in(0, 0, 0, 1, 0, 0, 0, 0); cycle("retire full");
    set_in(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("ovf credit_err", credit_err, 1);
    chk("ovf rob_free", dut.rob_free, ROBD);
    for (int i = 0; i < 3; i++) cycle("ovf hold");
    #1; chk("ovf sticky", credit_err, 1);
    do_reset();
    #1; chk("err cleared by reset", credit_err, 0);

    // Asynchronous reset in the middle of a flush.
    for (int i = 0; i < 2; i++) begin set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle("pre arst"); end
    set_in(0, 0, 0, 0, 1, 0, 0, 0); cycle("arst mis");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2; chk("arst flush before", flush, 1);
    reset = 1'b0;
    #1;
    chk("arst flush", flush, 0);
    chk("arst rob_free", dut.rob_free, ROBD);
    chk("arst rs_free0", dut.rs_free[0], RSD);
    chk("arst rs_free1", dut.rs_free[1], RSD);
    model_reset();
    @(negedge clock);
    reset = 1'b1;

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int rel;
      rel = 0;
      for (int i = 0; i < NRS; i++)
        if (m_rs[i] < RSD && $urandom_range(0, 9) < 4) rel |= (1 << i);
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 1), rel,
             (m_rob < ROBD) && ($urandom_range(0, 1) == 1),
             $urandom_range(0, 99) < 3,
             $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
